// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter that time-shares one ALU. A granted request is
// latched, executed in the following cycle, and returned as a one-cycle response.

module alu (
  input  logic [4:0]  opcode,
  input  logic [4:0]  shamt,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        is_ne,
  output logic        is_lt,
  output logic        ovf
);
  logic [31:0] sum, diff;
  logic        sub_ovf;

  always_comb begin
    sum     = a + b;
    diff    = a - b;
    sub_ovf = (a[31] != b[31]) && (diff[31] != a[31]);
    is_ne   = |diff;
    // signed less-than from the subtract: sign of the difference, corrected on overflow
    is_lt   = diff[31] ^ sub_ovf;
    result  = '0;
    ovf     = 1'b0;
    case (opcode)
      5'd0: begin
        result = sum;
        ovf    = (a[31] == b[31]) && (sum[31] != a[31]);
      end
      5'd1: begin
        result = diff;
        ovf    = sub_ovf;
      end
      5'd2: result = a & b;
      5'd3: result = a | b;
      5'd4: result = a << shamt;
      5'd5: result = $unsigned($signed(a) >>> shamt);
      default: result = '0;
    endcase
  end
endmodule

module alu_arbiter (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [4:0]  opcode0,
  input  logic [4:0]  opcode1,
  input  logic [4:0]  shamt0,
  input  logic [4:0]  shamt1,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        busy,
  output logic        resp_valid,
  output logic        resp_id,
  output logic [31:0] resp_result,
  output logic        resp_ne,
  output logic        resp_lt,
  output logic        resp_ovf
);
  typedef enum logic {IDLE, EXEC} state_t;

  state_t      state_q, state_d;
  logic        last_id_q, last_id_d;
  logic        cur_id_q, cur_id_d;
  logic [4:0]  opc_q, opc_d;
  logic [4:0]  shamt_q, shamt_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_id_q, resp_id_d;
  logic [31:0] resp_result_q, resp_result_d;
  logic        resp_ne_q, resp_ne_d;
  logic        resp_lt_q, resp_lt_d;
  logic        resp_ovf_q, resp_ovf_d;

  logic [31:0] alu_result;
  logic        alu_ne, alu_lt, alu_ovf;
  logic        accept, win_id;

  alu u_alu (
    .opcode (opc_q),
    .shamt  (shamt_q),
    .a      (a_q),
    .b      (b_q),
    .result (alu_result),
    .is_ne  (alu_ne),
    .is_lt  (alu_lt),
    .ovf    (alu_ovf)
  );

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b1 == 1'b0;
    if (state_q == IDLE && !reset) begin
      if (req0 && req1) begin
        gnt0 = last_id_q;
        gnt1 = !last_id_q;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  assign accept = gnt0 | gnt1;
  assign win_id = gnt1;

  always_comb begin
    state_d       = state_q;
    last_id_d     = last_id_q;
    cur_id_d      = cur_id_q;
    opc_d         = opc_q;
    shamt_d       = shamt_q;
    a_d           = a_q;
    b_d           = b_q;
    resp_valid_d  = 1'b0;
    resp_id_d     = resp_id_q;
    resp_result_d = resp_result_q;
    resp_ne_d     = resp_ne_q;
    resp_lt_d     = resp_lt_q;
    resp_ovf_d    = resp_ovf_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d   = EXEC;
        last_id_d = win_id;
        cur_id_d  = win_id;
        opc_d     = win_id ? opcode1 : opcode0;
        shamt_d   = win_id ? shamt1  : shamt0;
        a_d       = win_id ? a1      : a0;
        b_d       = win_id ? b1      : b0;
      end
      EXEC: begin
        state_d       = IDLE;
        resp_valid_d  = 1'b1;
        resp_id_d     = cur_id_q;
        resp_result_d = alu_result;
        // compare flags only mean something for sub, overflow only for add/sub
        resp_ne_d     = (opc_q == 5'd1) && alu_ne;
        resp_lt_d     = (opc_q == 5'd1) && alu_lt;
        resp_ovf_d    = (opc_q == 5'd0 || opc_q == 5'd1) && alu_ovf;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      last_id_q     <= 1'b1;
      cur_id_q      <= 1'b0;
      opc_q         <= '0;
      shamt_q       <= '0;
      a_q           <= '0;
      b_q           <= '0;
      resp_valid_q  <= 1'b0;
      resp_id_q     <= 1'b0;
      resp_result_q <= '0;
      resp_ne_q     <= 1'b0;
      resp_lt_q     <= 1'b0;
      resp_ovf_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_id_q     <= last_id_d;
      cur_id_q      <= cur_id_d;
      opc_q         <= opc_d;
      shamt_q       <= shamt_d;
      a_q           <= a_d;
      b_q           <= b_d;
      resp_valid_q  <= resp_valid_d;
      resp_id_q     <= resp_id_d;
      resp_result_q <= resp_result_d;
      resp_ne_q     <= resp_ne_d;
      resp_lt_q     <= resp_lt_d;
      resp_ovf_q    <= resp_ovf_d;
    end
  end

  assign busy        = (state_q == EXEC);
  assign resp_valid  = resp_valid_q;
  assign resp_id     = resp_id_q;
  assign resp_result = resp_result_q;
  assign resp_ne     = resp_ne_q;
  assign resp_lt     = resp_lt_q;
  assign resp_ovf    = resp_ovf_q;
endmodule
